// File: rtl/shifter_pkg.sv
// ---------------------------------------------------------------------------
// shifter_pkg
// Shared types and constants for the pipelined barrel shifter used in the
// floating-point adder datapath (alignment and normalisation shifts).
//
// Contents:
//   shift_mode_e  - shift operation encoding carried down the pipe
//   FP_MANT_W     - mantissa width used by the FP adder (default WIDTH)
//   FP_SHAMT_W    - shift-amount width used by the FP adder (default SHAMT_W)
//   stage_dist()  - shift distance handled by pipeline stage i (2^i)
// ---------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,  // logical left, zero fill from LSB
    SHIFT_SRL = 2'b01,  // logical right, zero fill from MSB
    SHIFT_SRA = 2'b10,  // arithmetic right, sign fill from MSB
    SHIFT_ROR = 2'b11   // rotate right
  } shift_mode_e;

  localparam int FP_MANT_W  = 11;
  localparam int FP_SHAMT_W = 5;

  // Stage i resolves shift-amount bit i, i.e. a shift of 2^i positions.
  function automatic int stage_dist(input int stage_idx);
    return 1 << stage_idx;
  endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter_if
// Input-beat and output-result channels of the pipelined barrel shifter.
//
// Handshake (both channels): a transfer happens on a rising clock edge where
// valid && ready are both 1. The producer holds valid and payload stable
// until the transfer; ready may depend combinationally on the downstream
// ready (in_ready follows out_ready through the stage chain).
//
// Signals:
//   in_valid / in_ready            input beat handshake
//   in_data [WIDTH]                operand
//   in_shamt[SHAMT_W]              unsigned shift amount
//   in_mode [2]                    00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid / out_ready          result handshake
//   out_data [WIDTH]               shifted result
//   out_sticky                     OR of bits discarded by a right shift
//
// Modports:
//   master - the side that issues beats and consumes results (environment)
//   slave  - the shifter itself
// ---------------------------------------------------------------------------
interface pipelined_barrel_shifter_if #(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 5
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_sticky;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );

endinterface

// File: rtl/barrel_shift_stage.sv
// ---------------------------------------------------------------------------
// barrel_shift_stage
// One level of the log-stage barrel shifter: conditionally shifts the
// incoming operand by a fixed distance DIST, accumulates the sticky bit,
// and registers the result together with the carried shamt/mode/valid.
//
// Parameters:
//   WIDTH   - data width
//   DIST    - fixed shift distance of this level (2^SEL_BIT)
//   SHAMT_W - width of the carried shift amount
//   SEL_BIT - shift-amount bit that enables this level
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   up_*_i              beat offered by the previous level (or the input)
//   down_adv_i          next level (or the consumer) can take our beat
//   advance_o           this level loads this cycle; ready for the upstream
//   valid_o, data_o,
//   shamt_o, mode_o,
//   sticky_o            registered beat presented to the next level
//
// Configuration macro: STICKY_EN. When undefined, no sticky register is
// built and sticky_o is tied to 0.
// ---------------------------------------------------------------------------
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 11,
  parameter int DIST    = 1,
  parameter int SHAMT_W = 5,
  parameter int SEL_BIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid_i,
  input  logic [WIDTH-1:0]   up_data_i,
  input  logic [SHAMT_W-1:0] up_shamt_i,
  input  shift_mode_e        up_mode_i,
  input  logic               up_sticky_i,
  input  logic               down_adv_i,
  output logic               advance_o,
  output logic               valid_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output shift_mode_e        mode_o,
  output logic               sticky_o
);

  // A level whose distance is at least WIDTH rotates by DIST mod WIDTH and
  // discards every bit on a right shift; both fall out of these constants.
  localparam int ROT  = DIST % WIDTH;
  localparam int LOST = (DIST < WIDTH) ? DIST : WIDTH;
  localparam logic [WIDTH-1:0] ONES      = '1;
  localparam logic [WIDTH-1:0] LOST_MASK = ~(ONES << LOST);

  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  shift_mode_e        mode_q,  mode_d;

  logic [WIDTH-1:0]   shifted;
  logic               lost_any;
  logic               load;

  // Combinational shift for this level.
  always_comb begin
    shifted  = up_data_i;
    lost_any = 1'b0;
    if (up_shamt_i[SEL_BIT]) begin
      case (up_mode_i)
        SHIFT_SLL: shifted = up_data_i << DIST;
        SHIFT_SRL: begin
          shifted  = up_data_i >> DIST;
          lost_any = |(up_data_i & LOST_MASK);
        end
        SHIFT_SRA: begin
          // MSB is still the original sign bit: earlier SRA levels refill it.
          shifted  = $unsigned($signed(up_data_i) >>> DIST);
          lost_any = |(up_data_i & LOST_MASK);
        end
        SHIFT_ROR: shifted = (up_data_i >> ROT) | (up_data_i << (WIDTH - ROT));
      endcase
    end
  end

  // An empty level always advances, which is what collapses bubbles.
  assign advance_o = !valid_q || down_adv_i;
  assign load      = advance_o && up_valid_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    if (advance_o) begin
      valid_d = up_valid_i;
    end
    if (load) begin
      data_d  = shifted;
      shamt_d = up_shamt_i;
      mode_d  = up_mode_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= SHIFT_SLL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
    end
  end

`ifdef STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (load) begin
      sticky_d = up_sticky_i | lost_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_o = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = up_sticky_i ^ lost_any;
  assign sticky_o      = 1'b0;
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign shamt_o = shamt_q;
  assign mode_o  = mode_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// ---------------------------------------------------------------------------
// pipelined_barrel_shifter
// Parametrised log-stage barrel shifter with one register per shift-amount
// bit. Supports SLL, SRL, SRA (with sticky) and ROR. Each level shifts by
// 2^i when bit i of the carried shamt is set. Levels advance independently
// so empty slots collapse while the output is stalled; ordering is FIFO.
//
// Parameters:
//   WIDTH   - data width (>= 2), default FP_MANT_W
//   SHAMT_W - shift-amount width and number of pipeline levels
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears every valid bit
//   bus    pipelined_barrel_shifter_if.slave (in_* beat, out_* result)
//
// Configuration macro: STICKY_EN. Defined builds the sticky chain; undefined
// ties out_sticky to 0 while keeping the port.
// ---------------------------------------------------------------------------
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = FP_MANT_W,
  parameter int SHAMT_W = FP_SHAMT_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pipelined_barrel_shifter_if.slave      bus
);

  // Index i is the beat entering level i; index SHAMT_W is the output.
  logic               stg_valid  [0:SHAMT_W];
  logic [WIDTH-1:0]   stg_data   [0:SHAMT_W];
  logic [SHAMT_W-1:0] stg_shamt  [0:SHAMT_W];
  shift_mode_e        stg_mode   [0:SHAMT_W];
  logic               stg_sticky [0:SHAMT_W];
  // stg_adv[i]: level i loads this cycle. stg_adv[SHAMT_W] is the consumer.
  logic               stg_adv    [0:SHAMT_W];

  assign stg_valid[0]  = bus.in_valid;
  assign stg_data[0]   = bus.in_data;
  assign stg_shamt[0]  = bus.in_shamt;
  assign stg_mode[0]   = shift_mode_e'(bus.in_mode);
  assign stg_sticky[0] = 1'b0;

  assign stg_adv[SHAMT_W] = bus.out_ready;

  for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH   (WIDTH),
      .DIST    (stage_dist(i)),
      .SHAMT_W (SHAMT_W),
      .SEL_BIT (i)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .up_valid_i  (stg_valid[i]),
      .up_data_i   (stg_data[i]),
      .up_shamt_i  (stg_shamt[i]),
      .up_mode_i   (stg_mode[i]),
      .up_sticky_i (stg_sticky[i]),
      .down_adv_i  (stg_adv[i+1]),
      .advance_o   (stg_adv[i]),
      .valid_o     (stg_valid[i+1]),
      .data_o      (stg_data[i+1]),
      .shamt_o     (stg_shamt[i+1]),
      .mode_o      (stg_mode[i+1]),
      .sticky_o    (stg_sticky[i+1])
    );
  end

  // Level 0 loading is exactly "stage 0 can accept", so in_ready is a pure
  // combinational function of out_ready and the valid bits.
  assign bus.in_ready   = stg_adv[0];
  assign bus.out_valid  = stg_valid[SHAMT_W];
  assign bus.out_data   = stg_data[SHAMT_W];
  // Each level already drives 0 here when the sticky chain is not built.
  assign bus.out_sticky = stg_sticky[SHAMT_W];

  // Shamt and mode of the last level have no further consumer.
  logic unused_tail;
  assign unused_tail = ^{stg_shamt[SHAMT_W], stg_mode[SHAMT_W]};

endmodule
